// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit index counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer: valid/ready word load, shift_en pacing,
// selectable bit order, registered serial bit with frame_start/frame_last markers.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int            CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             at_last;
  logic             accept;
  logic             load_bit;
  logic             shift_bit;

  assign at_last  = (cnt == LAST);
  assign in_ready = !reset && ((state == ST_IDLE) || (at_last && shift_en));
  assign accept   = in_valid && in_ready;

  // serial_out is registered, so it takes the bit the next shreg value will present.
  assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign load_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign shift_bit = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];

  assign busy = serial_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;
    end else if (accept) begin
      state        <= ST_SHIFT;
      cnt          <= '0;
      shreg        <= in_data;
      serial_out   <= load_bit;
      serial_valid <= 1'b1;
      frame_start  <= 1'b1;
      frame_last   <= 1'b0;
    end else if ((state == ST_SHIFT) && shift_en) begin
      if (!at_last) begin
        cnt         <= cnt + 1'b1;
        shreg       <= shifted;
        serial_out  <= shift_bit;
        frame_start <= 1'b0;
        frame_last  <= (cnt == PENULT);
      end else begin
        // Final bit consumed with no follow-on word: return to idle.
        state        <= ST_IDLE;
        cnt          <= '0;
        shreg        <= '0;
        serial_out   <= 1'b0;
        serial_valid <= 1'b0;
        frame_start  <= 1'b0;
        frame_last   <= 1'b0;
      end
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: four serializer configurations share stimulus; each has a
// queue of expected bits filled on accept and drained on shift_en edges.
module tb_piso_serializer;

  localparam int NI = 4;
  localparam int QD = 16;
  localparam int WID  [NI] = '{8, 8, 3, 3};
  localparam bit MSBF [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic       shift_en = 1'b0;
  logic [7:0] in_data  = 8'h00;

  logic so [NI];
  logic sv [NI];
  logic fs [NI];
  logic fl [NI];
  logic bz [NI];
  logic rdy[NI];

  // expected entries {last, start, bit}, circular per instance
  logic [2:0] ebuf [NI][QD];
  int head [NI];
  int fill [NI];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .shift_en(shift_en), .serial_out(so[0]), .serial_valid(sv[0]), .frame_start(fs[0]),
    .frame_last(fl[0]), .busy(bz[0]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .shift_en(shift_en), .serial_out(so[1]), .serial_valid(sv[1]), .frame_start(fs[1]),
    .frame_last(fl[1]), .busy(bz[1]));
  piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data[2:0]),
    .shift_en(shift_en), .serial_out(so[2]), .serial_valid(sv[2]), .frame_start(fs[2]),
    .frame_last(fl[2]), .busy(bz[2]));
  piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b0)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data[2:0]),
    .shift_en(shift_en), .serial_out(so[3]), .serial_valid(sv[3]), .frame_start(fs[3]),
    .frame_last(fl[3]), .busy(bz[3]));

  function automatic logic model_ready(input int i);
    return !reset && ((fill[i] == 0) || ((fill[i] == 1) && shift_en));
  endfunction

  // Reference model step at a rising edge: consume a bit, then enqueue an accepted word.
  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      logic acc;
      logic b;
      if (reset) begin
        head[i] = 0;
        fill[i] = 0;
      end else begin
        acc = in_valid && model_ready(i);
        if (shift_en && (fill[i] > 0)) begin
          head[i] = (head[i] + 1) % QD;
          fill[i] = fill[i] - 1;
        end
        if (acc) begin
          for (int k = 0; k < WID[i]; k++) begin
            b = MSBF[i] ? in_data[WID[i]-1-k] : in_data[k];
            ebuf[i][(head[i] + fill[i]) % QD] = {(k == WID[i]-1), (k == 0), b};
            fill[i] = fill[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    shift_en = s;
    in_data  = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Reset-state check: every output of every instance must be 0 while reset is high.
  task automatic check_reset_state(input string tag);
    logic [5:0] act_v;
    for (int i = 0; i < NI; i++) begin
      act_v = {rdy[i], bz[i], fl[i], fs[i], sv[i], so[i]};
      checks = checks + 1;
      if (act_v !== 6'b000000) begin
        errors = errors + 1;
        $display("FAIL reset-state %s inst%0d t=%0t: ready/busy/last/start/valid/out got %b want 000000",
                 tag, i, $time, act_v);
      end
    end
  endtask

  // Bounded wait for all instances to be ready; reports a failure if the wait expires.
  task automatic wait_ready(input int max_cycles);
    int  n;
    logic all_rdy;
    n = 0;
    all_rdy = 1'b0;
    while (!all_rdy && (n < max_cycles)) begin
      all_rdy = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (rdy[i] !== 1'b1) begin
          all_rdy = 1'b0;
        end
      end
      if (!all_rdy) begin
        cycle(1'b0, 1'b1, 8'h00);
        n = n + 1;
      end
    end
    checks = checks + 1;
    if (!all_rdy) begin
      errors = errors + 1;
      $display("FAIL wait for in_ready expired after %0d cycles t=%0t", max_cycles, $time);
    end
  endtask

  // Monitor: compare every instance's outputs against the queue head mid-cycle.
  always @(negedge clk) begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    logic [2:0] ent;
    for (int i = 0; i < NI; i++) begin
      act_v = {rdy[i], bz[i], fl[i], fs[i], sv[i], so[i]};
      if (reset) begin
        exp_v = 6'b000000;
      end else if (fill[i] > 0) begin
        ent   = ebuf[i][head[i]];
        exp_v = {model_ready(i), 1'b1, ent[2], ent[1], 1'b1, ent[0]};
      end else begin
        exp_v = {model_ready(i), 5'b00000};
      end
      checks = checks + 1;
      if (act_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL inst%0d (W=%0d msb_first=%0b) t=%0t: ready/busy/last/start/valid/out got %b want %b",
                 i, WID[i], MSBF[i], $time, act_v, exp_v);
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      head[i] = 0;
      fill[i] = 0;
    end
    reset = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    check_reset_state("initial");
    reset = 1'b0;

    // single word, MSB/LSB patterns
    cycle(1'b1, 1'b1, 8'h01);
    repeat (10) cycle(1'b0, 1'b1, 8'($urandom));
    cycle(1'b1, 1'b1, 8'h04);
    repeat (10) cycle(1'b0, 1'b1, 8'($urandom));

    // back-to-back words, in_valid held high
    cycle(1'b1, 1'b1, 8'hA5);
    repeat (7) cycle(1'b1, 1'b1, 8'h5A);
    cycle(1'b1, 1'b1, 8'h3C);
    repeat (12) cycle(1'b0, 1'b1, 8'h00);

    // stall after bit 2
    cycle(1'b1, 1'b1, 8'hF0);
    repeat (2) cycle(1'b0, 1'b1, 8'h00);
    repeat (5) cycle(1'b0, 1'b0, 8'h00);
    repeat (12) cycle(1'b0, 1'b1, 8'h00);

    // asynchronous reset mid-word, then a clean load
    cycle(1'b1, 1'b1, 8'hFF);
    repeat (3) cycle(1'b0, 1'b1, 8'h00);
    reset = 1'b1;
    #1;
    check_reset_state("async");
    repeat (2) cycle(1'b0, 1'b1, 8'h00);
    reset = 1'b0;
    #1;
    wait_ready(4);
    cycle(1'b1, 1'b1, 8'h81);
    repeat (12) cycle(1'b0, 1'b1, 8'h00);

    // in_data toggling while busy must not disturb the word
    cycle(1'b1, 1'b1, 8'hC3);
    repeat (12) cycle(1'b0, 1'b1, 8'($urandom));

    // randomized traffic with occasional reset pulses
    repeat (800) begin
      reset = ($urandom_range(0, 149) == 0);
      cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    reset = 1'b0;
    repeat (20) cycle(1'b0, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, a shift-enable input for bit pacing, selectable bit order, and frame markers. It sits between a word-oriented producer and a bit-serial link such as a UART/SPI-style transmitter or an LED-chain driver. It replaces the fixed 3-bit load/shift register: the word width is generic, a new word can be loaded back-to-back with no idle bit, and the downstream side can stall shifting.

## Interface
- WIDTH, 8, word width in bits; legal range is ≥ 2.
- MSB_FIRST, 1, bit order: 1 shifts in_data[WIDTH-1] first, 0 shifts in_data[0] first.
- clk  in  1  rising-edge clock.
- reset  in  1  one clock; reset is asynchronous and active-high.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  block accepts in_data this cycle; combinational.
- in_data  in  WIDTH  parallel word.
- shift_en  in  1  bit-rate enable: while high, the presented bit is consumed at the next edge.
- serial_out  out  1  current serial bit; registered.
- serial_valid  out  1  serial_out holds a valid bit; registered.
- frame_start  out  1  serial_out is bit 0 of a word; registered.
- frame_last  out  1  serial_out is the final bit of a word; registered.
- busy  out  1  a word is loaded and not yet fully shifted; equals serial_valid.

## Operation
- Two states:
  - IDLE: no word held.
  - SHIFT: a word is held. shreg (WIDTH) holds the word; cnt (CW = $clog2(WIDTH)) holds the index of the presented bit.
- in_ready is 1 in IDLE. In SHIFT it is 1 only when cnt == WIDTH-1 and shift_en == 1. It is forced to 0 while reset is asserted.
- Accept means in_valid && in_ready at a rising edge. On accept:
  - shreg <= in_data, cnt <= 0, state <= SHIFT.
  - serial_out becomes the first bit in the configured order.
  - frame_start <= 1.
- In SHIFT with shift_en = 1 and cnt < WIDTH-1:
  - shreg shifts toward the output: left for MSB_FIRST, right otherwise; zero fill.
  - cnt increments and frame_start <= 0.
  - frame_last <= (cnt+1 == WIDTH-1).
- In SHIFT with shift_en = 1 and cnt == WIDTH-1:
  - If in_valid is high, the next word is accepted in the same edge. There is no gap bit.
  - Otherwise state <= IDLE, serial_valid <= 0, and all markers clear.
- In SHIFT with shift_en = 0, every register holds, so the presented bit is stable for any number of cycles.
- While in IDLE, serial_out is 0.
- The serial bit is taken from shreg[WIDTH-1] when MSB_FIRST and from shreg[0] otherwise. serial_out is a registered copy aligned with the markers.
- in_data is sampled only on accept. Changes at other times have no effect.

## Timing
- Reset values: serial_out 0, serial_valid 0, busy 0, frame_start 0, frame_last 0, state IDLE, cnt 0, shreg 0.
- Reset is asynchronous: asserting it mid-word discards the word immediately.
- After reset deasserts, in_ready = 1 in the first cycle.
- Latency: the first bit appears on serial_out in the cycle after the accept edge.
- Shifting a word takes WIDTH shift_en-qualified edges. With shift_en tied high, one word takes exactly WIDTH cycles, and back-to-back words stream continuously.
- frame_start and frame_last are never high together, because WIDTH ≥ 2.
- The in_ready → in_valid path is combinational. in_valid must not depend combinationally on in_ready.

## Structure
- Constants: a shared package piso_pkg holds the state enum (ST_IDLE, ST_SHIFT) and a helper function for counter width.
- No sub-module is needed. Keep a single always block for the state, cnt and shreg registers, plus continuous assigns for in_ready and the bit select.

## Test plan
- Basic MSB-first load: WIDTH=3, MSB_FIRST=1, shift_en=1, load 3'b001 → serial_out 0,0,1 on three consecutive cycles. frame_start is on the first bit, frame_last on the third, then serial_valid drops.
- LSB-first order: WIDTH=3, MSB_FIRST=0, load 3'b100 → serial_out 0,0,1.
- Back-to-back words: WIDTH=8, in_valid held with 8'hA5 then 8'h3C → 16 contiguous valid bits 10100101 00111100. in_ready pulses on each last bit, and frame_start is high on cycles 1 and 9.
- Stall: WIDTH=8, load 8'hF0, shift_en low for 5 cycles after bit 2 → bit 2 is held for 6 cycles, and the remaining bits are unchanged.
- Mid-word reset: WIDTH=8, assert reset after bit 3 of 8'hFF → all outputs are 0 within the same cycle. After release, in_ready = 1 and the next load of 8'h81 shifts cleanly.
- No-accept: WIDTH=8, toggle in_data while busy with in_valid=0 → the output sequence matches the originally loaded word.
